// File: rtl/tb4004_pkg.sv
// Shared definitions for the 4004-style fetch path: cycle codes, opcode constants, fetch state.
// Latency: none (types, constants and a pure function only).
// Backpressure: none; the cycle counter paces every consumer of this package.
package tb4004_pkg;

    // clockReset phase codes, one per clock of the 8-clock instruction cycle
    localparam logic [2:0] CYC_A1 = 3'd0;
    localparam logic [2:0] CYC_A2 = 3'd1;
    localparam logic [2:0] CYC_A3 = 3'd2;
    localparam logic [2:0] CYC_M1 = 3'd3;
    localparam logic [2:0] CYC_M2 = 3'd4;
    localparam logic [2:0] CYC_X1 = 3'd5;
    localparam logic [2:0] CYC_X2 = 3'd6;
    localparam logic [2:0] CYC_X3 = 3'd7;

    // OPR nibbles of the opcodes that carry a second instruction word
    localparam logic [3:0] OPR_JCN     = 4'h1;
    localparam logic [3:0] OPR_FIM_SRC = 4'h2;
    localparam logic [3:0] OPR_JUN     = 4'h4;
    localparam logic [3:0] OPR_JMS     = 4'h5;
    localparam logic [3:0] OPR_ISZ     = 4'h7;

    // FETCH1 collects OPR/OPA of the first word, FETCH2 the second word
    typedef enum logic {
        FETCH1 = 1'b0,
        FETCH2 = 1'b1
    } fetchState_t;

    // True when the opcode needs a second word. OPR 2 is shared by FIM
    // (OPA[0]=0, two words) and SRC (OPA[0]=1, one word).
    function automatic logic isTwoWord(input logic [3:0] opr, input logic [3:0] opa);
        logic result;
        result = 1'b0;
        case (opr)
            OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: result = 1'b1;
            OPR_FIM_SRC:                        result = ~opa[0];
            default:                            result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/instr_fetch_latch.sv
// Assembles ROM nibbles into one atomic instruction (opr, opa, 8-bit operand) for the decoder.
// Latency: instrValid pulses for the single clock after the final M2 edge (the X1 cycle).
// Backpressure: none; capture is paced by the cycle code, flush discards a partial fetch.
module instr_fetch_latch
    import tb4004_pkg::*;
#(
    parameter logic [2:0] CYCLE_M1 = CYC_M1,
    parameter logic [2:0] CYCLE_M2 = CYC_M2,
    parameter logic [2:0] CYCLE_X1 = CYC_X1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cycle,
    input  logic [3:0] romData,
    input  logic       flush,
    output logic [3:0] opr,
    output logic [3:0] opa,
    output logic [7:0] operand,
    output logic       twoWord,
    output logic       instrValid,
    output logic       fetchWord2
);

    fetchState_t state;
    fetchState_t stateNext;

    // Holding registers for the instruction being assembled; never visible
    // on the outputs until the whole instruction is complete.
    logic [3:0] oprHold;
    logic [3:0] opaHold;
    logic [3:0] op2Hi;

    logic [3:0] oprHoldNext;
    logic [3:0] opaHoldNext;
    logic [3:0] op2HiNext;

    logic [3:0] oprNext;
    logic [3:0] opaNext;
    logic [7:0] operandNext;
    logic       twoWordNext;
    logic       instrValidNext;
    logic       fetchWord2Next;

    logic       isM1;
    logic       isM2;

    assign isM1 = (cycle == CYCLE_M1);
    assign isM2 = (cycle == CYCLE_M2);

    // Next-state and capture decisions; flush overrides any M1/M2 capture
    always_comb begin
        stateNext      = state;
        oprHoldNext    = oprHold;
        opaHoldNext    = opaHold;
        op2HiNext      = op2Hi;
        oprNext        = opr;
        opaNext        = opa;
        operandNext    = operand;
        twoWordNext    = twoWord;
        fetchWord2Next = fetchWord2;
        instrValidNext = 1'b0;

        if (flush) begin
            // Published outputs are kept; only the partial fetch is dropped.
            stateNext      = FETCH1;
            fetchWord2Next = 1'b0;
            oprHoldNext    = 4'h0;
            opaHoldNext    = 4'h0;
            op2HiNext      = 4'h0;
        end else if (isM1) begin
            if (state == FETCH1) begin
                oprHoldNext = romData;
            end else begin
                op2HiNext = romData;
            end
        end else if (isM2) begin
            if (state == FETCH1) begin
                opaHoldNext = romData;
                if (isTwoWord(oprHold, romData)) begin
                    // Outputs stay frozen until the operand word arrives.
                    stateNext      = FETCH2;
                    fetchWord2Next = 1'b1;
                end else begin
                    oprNext        = oprHold;
                    opaNext        = romData;
                    operandNext    = 8'h00;
                    twoWordNext    = 1'b0;
                    instrValidNext = 1'b1;
                end
            end else begin
                oprNext        = oprHold;
                opaNext        = opaHold;
                operandNext    = {op2Hi, romData};
                twoWordNext    = 1'b1;
                instrValidNext = 1'b1;
                fetchWord2Next = 1'b0;
                stateNext      = FETCH1;
            end
        end
    end

    // State, holding registers and published outputs, all cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH1;
            oprHold    <= 4'h0;
            opaHold    <= 4'h0;
            op2Hi      <= 4'h0;
            opr        <= 4'h0;
            opa        <= 4'h0;
            operand    <= 8'h00;
            twoWord    <= 1'b0;
            instrValid <= 1'b0;
            fetchWord2 <= 1'b0;
        end else begin
            state      <= stateNext;
            oprHold    <= oprHoldNext;
            opaHold    <= opaHoldNext;
            op2Hi      <= op2HiNext;
            opr        <= oprNext;
            opa        <= opaNext;
            operand    <= operandNext;
            twoWord    <= twoWordNext;
            instrValid <= instrValidNext;
            fetchWord2 <= fetchWord2Next;
        end
    end

    // The completion strobe can only ever be seen during the X1 slot
    strobeInX1 : assert property (@(posedge clk) disable iff (rst)
        instrValid |-> (cycle == CYCLE_X1));

endmodule
